rx_seq_ctrl: RTL and testbench
==============================

Name: rx_seq_ctrl

Overview:
Receive-burst sequencer for the rx datapath.
- Drives the rx start and AGC-enable control bits.
- Arms the receiver, runs AGC until a packet is detected, then freezes gain for the payload.
- Ends each burst on frame-done or a sample-count timeout, then forces a start-low gap before re-arming.
- Runs in the rx ADC clock domain (32 MHz, one valid sample per 8 clocks); software config arrives already synchronised.

Parameters:
GAP_CYC, 6, clocks o_start is held low between bursts (min 1)
CNT_W, 16, width of the timeout and statistics counters

Ports:
i_clk  in  1  rx ADC-domain clock
i_rstn  in  1  synchronous reset, active low
i_enable  in  1  level; 1 = run sequencer
i_oneshot  in  1  1 = return to IDLE after one burst
i_agc_samps  in  8  valid samples of AGC settling after detect; 0 = skip AGC state
i_timeout_samps  in  CNT_W  valid-sample limit in RECV; 0 = no timeout
i_clr_stats  in  1  pulse; clears statistics counters
i_sample_vld  in  1  ADC sample strobe (same as rx input valid)
i_pkt_det  in  1  preamble/threshold detect pulse from rx
i_frame_done  in  1  end-of-frame pulse from rx
o_start  out  1  rx start control bit
o_agc_en_n  out  1  rx AGC enable, active low
o_busy  out  1  1 when state != IDLE
o_state  out  3  current state encoding
o_frame_pulse  out  1  one-clock pulse per completed frame
o_frame_cnt  out  CNT_W  completed frames
o_timeout_cnt  out  CNT_W  bursts ended by timeout

Behaviour:
- All outputs are registered. Outputs follow the state register in the same cycle it updates, so there is one clock of latency from the input that causes a transition.
- Reset (i_rstn=0 at posedge): state IDLE, o_start=0, o_agc_en_n=1, o_busy=0, o_frame_pulse=0, all counters 0. Reset mid-burst aborts immediately; no counter is updated.
- State encodings: IDLE=0, ARM=1, SEARCH=2, AGC=3, RECV=4, GAP=5. Values 6 and 7 recover to IDLE.
- IDLE: o_start=0, o_agc_en_n=1. Goes to ARM when i_enable=1.
- ARM: lasts exactly 1 clock. o_start=1, o_agc_en_n=0. Goes to SEARCH.
- SEARCH: o_start=1, o_agc_en_n=0.
  - i_pkt_det=1 -> AGC, or -> RECV if i_agc_samps=0.
  - i_enable=0 with no detect -> GAP (abort).
  - Detect wins over disable in the same cycle.
- AGC: o_start=1, o_agc_en_n=0.
  - Counts i_sample_vld strobes; after i_agc_samps strobes -> RECV.
  - i_pkt_det is ignored here.
- RECV: o_start=1, o_agc_en_n=1 (gain frozen).
  - Sample counter clears on entry and increments on each i_sample_vld.
  - i_frame_done -> GAP, with o_frame_pulse=1 for 1 clock and o_frame_cnt+1.
  - Else, counter reaching i_timeout_samps (when nonzero) -> GAP, with o_timeout_cnt+1.
  - Done and timeout in the same cycle: done wins; only o_frame_cnt increments.
  - i_enable=0 does not abort RECV or AGC; the burst completes normally.
- GAP: o_start=0, o_agc_en_n=1.
  - Held for exactly GAP_CYC clocks.
  - Then -> ARM if i_enable=1 and i_oneshot=0; otherwise -> IDLE.
- i_frame_done and i_pkt_det outside their consuming states are ignored.
- Config inputs are sampled live. Changing i_timeout_samps mid-RECV uses the new value on the next compare.
- Statistics counters:
  - Saturate at all-ones.
  - i_clr_stats zeroes both counters.
  - Clear and increment in the same cycle leaves the counter at 0.
  - Counters are not cleared by IDLE, only by reset or i_clr_stats.

Optional Feature:
RX_SEQ_STATS_EN
- Defined: o_frame_cnt and o_timeout_cnt are implemented as specified.
- Undefined: both are tied to 0, their registers are not built, and i_clr_stats is ignored.
- o_frame_pulse and the timeout-driven transition are present in both builds.

Test Plan:
- Reset, i_enable=1, strobe every 8 clocks, i_agc_samps=4, detect at strobe 10, i_frame_done 200 strobes later -> o_start high from clock after enable; o_agc_en_n 0->1 on 4th post-detect strobe; on done, one o_frame_pulse, o_frame_cnt=1, o_start low exactly 6 clocks, then ARM again.
- i_timeout_samps=50, detect but no frame_done -> RECV exits after 50th strobe; o_timeout_cnt=1; o_frame_cnt unchanged.
- i_frame_done coincident with 50th strobe (timeout=50) -> o_frame_cnt+1, o_timeout_cnt unchanged.
- i_enable=0 while in SEARCH -> GAP next clock, IDLE after 6 clocks. i_enable=0 while in RECV -> burst still completes on frame_done, then IDLE.
- i_oneshot=1, i_agc_samps=0 -> detect goes directly SEARCH->RECV; after the frame, GAP then IDLE with o_busy=0.
- i_rstn=0 mid-RECV, then preset o_frame_cnt=0xFFFF with further frames -> all outputs at reset values next clock; counter holds 0xFFFF; i_clr_stats coincident with frame_done -> 0. Repeat without RX_SEQ_STATS_EN -> counters always 0.

Source files
------------

// File: rtl/rx_seq_ctrl.sv
// rx_seq_ctrl: receive-burst sequencer for the rx datapath.
// Arms the receiver, runs AGC after packet detect, freezes gain for the payload,
// ends each burst on frame-done or a sample-count timeout and forces a start-low
// gap before re-arming. All outputs are registered.
// Build option: define RX_SEQ_STATS_EN to implement the frame/timeout counters;
// without it both counters read 0 and i_clr_stats is ignored.
module rx_seq_ctrl #(
  parameter int unsigned GAP_CYC = 6,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_enable,
  input  logic             i_oneshot,
  input  logic [7:0]       i_agc_samps,
  input  logic [CNT_W-1:0] i_timeout_samps,
  input  logic             i_clr_stats,
  input  logic             i_sample_vld,
  input  logic             i_pkt_det,
  input  logic             i_frame_done,
  output logic             o_start,
  output logic             o_agc_en_n,
  output logic             o_busy,
  output logic [2:0]       o_state,
  output logic             o_frame_pulse,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_timeout_cnt
);

  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArm    = 3'd1,
    StSearch = 3'd2,
    StAgc    = 3'd3,
    StRecv   = 3'd4,
    StGap    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]       agc_cnt_q, agc_cnt_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic             start_q, start_d;
  logic             agc_en_n_q, agc_en_n_d;
  logic             busy_q, busy_d;
  logic             frame_pulse_q, frame_pulse_d;
  logic             frame_evt, timeout_evt;
  logic [8:0]       agc_inc;
  logic [CNT_W:0]   smp_inc;

  // Next-state logic: burst sequencing and per-state sample/gap counters.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    agc_cnt_d   = agc_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    frame_evt   = 1'b0;
    timeout_evt = 1'b0;
    // Compare the post-strobe count so the exit happens on the Nth strobe itself.
    agc_inc     = {1'b0, agc_cnt_q} + 9'd1;
    smp_inc     = {1'b0, smp_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    unique case (state_q)
      StIdle: begin
        if (i_enable) state_d = StArm;
      end
      StArm: begin
        state_d = StSearch;
      end
      StSearch: begin
        // Detect has priority over disable.
        if (i_pkt_det) begin
          agc_cnt_d = '0;
          smp_cnt_d = '0;
          state_d   = (i_agc_samps == 8'd0) ? StRecv : StAgc;
        end else if (!i_enable) begin
          gap_cnt_d = '0;
          state_d   = StGap;
        end
      end
      StAgc: begin
        if (i_sample_vld) begin
          // >= so a live lowering of the setting still terminates the state.
          if (agc_inc >= {1'b0, i_agc_samps}) begin
            smp_cnt_d = '0;
            state_d   = StRecv;
          end else begin
            agc_cnt_d = agc_inc[7:0];
          end
        end
      end
      StRecv: begin
        if (i_frame_done) begin
          frame_evt = 1'b1;
          gap_cnt_d = '0;
          state_d   = StGap;
        end else if (i_sample_vld) begin
          if ((i_timeout_samps != '0) && (smp_inc >= {1'b0, i_timeout_samps})) begin
            timeout_evt = 1'b1;
            gap_cnt_d   = '0;
            state_d     = StGap;
          end else if (!(&smp_cnt_q)) begin
            smp_cnt_d = smp_inc[CNT_W-1:0];
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYC - 1)) begin
          state_d = (i_enable && !i_oneshot) ? StArm : StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + {{(GapW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state so registered outputs track the state register.
  always_comb begin
    start_d    = 1'b0;
    agc_en_n_d = 1'b1;
    case (state_d)
      StArm, StSearch, StAgc: begin
        start_d    = 1'b1;
        agc_en_n_d = 1'b0;
      end
      StRecv: begin
        start_d = 1'b1;
      end
      default: begin
        start_d    = 1'b0;
        agc_en_n_d = 1'b1;
      end
    endcase
    busy_d        = (state_d != StIdle);
    frame_pulse_d = frame_evt;
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q       <= StIdle;
      gap_cnt_q     <= '0;
      agc_cnt_q     <= '0;
      smp_cnt_q     <= '0;
      start_q       <= 1'b0;
      agc_en_n_q    <= 1'b1;
      busy_q        <= 1'b0;
      frame_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      agc_cnt_q     <= agc_cnt_d;
      smp_cnt_q     <= smp_cnt_d;
      start_q       <= start_d;
      agc_en_n_q    <= agc_en_n_d;
      busy_q        <= busy_d;
      frame_pulse_q <= frame_pulse_d;
    end
  end

  assign o_start       = start_q;
  assign o_agc_en_n    = agc_en_n_q;
  assign o_busy        = busy_q;
  assign o_state       = state_q;
  assign o_frame_pulse = frame_pulse_q;

`ifdef RX_SEQ_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;

  // Saturating statistics; clear wins over a same-cycle increment.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    if (i_clr_stats) begin
      frame_cnt_d   = '0;
      timeout_cnt_d = '0;
    end else begin
      if (frame_evt && !(&frame_cnt_q)) begin
        frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (timeout_evt && !(&timeout_cnt_q)) begin
        timeout_cnt_d = timeout_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      frame_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign o_frame_cnt   = frame_cnt_q;
  assign o_timeout_cnt = timeout_cnt_q;
`else
  logic unused_stats;
  assign unused_stats  = ^{i_clr_stats, timeout_evt};
  assign o_frame_cnt   = '0;
  assign o_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_seq_ctrl.sv
// Self-checking bench for rx_seq_ctrl: cycle table, directed burst scenarios and
// randomized traffic compared every clock against a behavioural burst model.
module tb_rx_seq_ctrl;

  localparam int unsigned CW   = 8;
  localparam int unsigned GAP  = 6;
  localparam int          MAXC = (1 << CW) - 1;
`ifdef RX_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0, en = 1'b0, oneshot = 1'b0, clr = 1'b0;
  logic          vld = 1'b0, det = 1'b0, done = 1'b0;
  logic [7:0]    agc = 8'd0;
  logic [CW-1:0] tmo = '0;
  logic          o_start, o_agc_en_n, o_busy, o_frame_pulse;
  logic [2:0]    o_state;
  logic [CW-1:0] o_frame_cnt, o_timeout_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int ph     = 0;
  bit auto_vld = 1'b0;

  // Model: burst phase plus event counts
  int m_phase = 0, m_agc_seen = 0, m_samps = 0, m_gap_left = 0;
  int m_frames = 0, m_touts = 0;
  bit m_pulse = 1'b0;

  rx_seq_ctrl #(.GAP_CYC(GAP), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en), .i_oneshot(oneshot),
    .i_agc_samps(agc), .i_timeout_samps(tmo), .i_clr_stats(clr),
    .i_sample_vld(vld), .i_pkt_det(det), .i_frame_done(done),
    .o_start(o_start), .o_agc_en_n(o_agc_en_n), .o_busy(o_busy), .o_state(o_state),
    .o_frame_pulse(o_frame_pulse), .o_frame_cnt(o_frame_cnt), .o_timeout_cnt(o_timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
  endtask

  // Phases: 0 idle, 1 arm, 2 search, 3 agc, 4 recv, 5 gap
  task automatic model_step();
    bit fr, to_ev;
    fr = 1'b0;
    to_ev = 1'b0;
    if (!rstn) begin
      m_phase = 0; m_pulse = 1'b0; m_frames = 0; m_touts = 0;
      return;
    end
    m_pulse = 1'b0;
    case (m_phase)
      0: if (en) m_phase = 1;
      1: m_phase = 2;
      2: begin
        if (det) begin
          m_agc_seen = 0; m_samps = 0;
          m_phase = (agc == 8'd0) ? 4 : 3;
        end else if (!en) begin
          m_phase = 5; m_gap_left = GAP;
        end
      end
      3: begin
        if (vld) begin
          m_agc_seen++;
          if (m_agc_seen >= int'(agc)) begin m_phase = 4; m_samps = 0; end
        end
      end
      4: begin
        if (done) begin
          fr = 1'b1; m_pulse = 1'b1; m_phase = 5; m_gap_left = GAP;
        end else if (vld) begin
          m_samps++;
          if (tmo != '0 && m_samps >= int'(tmo)) begin
            to_ev = 1'b1; m_phase = 5; m_gap_left = GAP;
          end
        end
      end
      5: begin
        m_gap_left--;
        if (m_gap_left == 0) m_phase = (en && !oneshot) ? 1 : 0;
      end
      default: m_phase = 0;
    endcase
    if (clr) begin
      m_frames = 0; m_touts = 0;
    end else begin
      if (fr && m_frames < MAXC) m_frames++;
      if (to_ev && m_touts < MAXC) m_touts++;
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [2:0]    st;
    logic          s, an, b;
    logic [CW-1:0] f, t;
    st = 3'(m_phase);
    s  = (m_phase >= 1 && m_phase <= 4);
    an = !(m_phase >= 1 && m_phase <= 3);
    b  = (m_phase != 0);
    f  = STATS ? CW'(m_frames) : '0;
    t  = STATS ? CW'(m_touts) : '0;
    return 32'({st, s, an, b, m_pulse, f, t});
  endfunction

  // One clock: optional periodic strobe, edge, model update, compare off-edge.
  task automatic cyc();
    if (auto_vld) vld = (ph == 7);
    ph = (ph + 1) % 8;
    @(posedge clk);
    model_step();
    #1;
    chk("model", 32'({o_state, o_start, o_agc_en_n, o_busy, o_frame_pulse,
                      o_frame_cnt, o_timeout_cnt}), model_vec());
  endtask

  task automatic wait_strobes(input int n, input bit det_last, input bit done_last);
    int seen, guard;
    seen = 0;
    guard = 0;
    while (seen < n && guard < n * 8 + 16) begin
      if (ph == 7 && seen == n - 1) begin det = det_last; done = done_last; end
      if (ph == 7) seen++;
      cyc();
      det = 1'b0;
      done = 1'b0;
      guard++;
    end
    if (seen < n) chk("strobe_budget", 32'(seen), 32'(n));
  endtask

  task automatic wait_state(input logic [2:0] s);
    int k;
    k = 0;
    while (o_state !== s && k < 400) begin cyc(); k++; end
    chk("wait_state", 32'(o_state), 32'(s));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(o_state), 32'd0);
    chk({tag, "_start"}, 32'(o_start), 32'd0);
    chk({tag, "_agc_en_n"}, 32'(o_agc_en_n), 32'd1);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_pulse"}, 32'(o_frame_pulse), 32'd0);
    chk({tag, "_fcnt"}, 32'(o_frame_cnt), 32'd0);
    chk({tag, "_tcnt"}, 32'(o_timeout_cnt), 32'd0);
  endtask

  typedef struct packed {
    logic       rstn, en, os, vld, det, done;
    logic [2:0] st;
    logic       start, agcn, pulse;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] ins, input logic [2:0] st,
                              input logic [2:0] outs);
    vec_t v;
    {v.rstn, v.en, v.os, v.vld, v.det, v.done} = ins;
    v.st = st;
    {v.start, v.agcn, v.pulse} = outs;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    int gap_len;
    // rstn en os vld det done | state | start agcn pulse
    tbl[0]  = mk(6'b000000, 3'd0, 3'b010);
    tbl[1]  = mk(6'b110000, 3'd1, 3'b100);
    tbl[2]  = mk(6'b110010, 3'd2, 3'b100);
    tbl[3]  = mk(6'b110010, 3'd3, 3'b100);
    tbl[4]  = mk(6'b100010, 3'd3, 3'b100);
    tbl[5]  = mk(6'b100100, 3'd4, 3'b110);
    tbl[6]  = mk(6'b100100, 3'd4, 3'b110);
    tbl[7]  = mk(6'b100001, 3'd5, 3'b011);
    for (int i = 8; i <= 12; i++) tbl[i] = mk(6'b111000, 3'd5, 3'b010);
    tbl[13] = mk(6'b111000, 3'd0, 3'b010);
    tbl[14] = mk(6'b110000, 3'd1, 3'b100);
    tbl[15] = mk(6'b100000, 3'd2, 3'b100);
    tbl[16] = mk(6'b100000, 3'd5, 3'b010);
    tbl[17] = mk(6'b000001, 3'd0, 3'b010);

    // Cycle table: agc=1 sample, no timeout
    agc = 8'd1;
    tmo = '0;
    #2;
    for (int i = 0; i < 18; i++) begin
      {rstn, en, oneshot, vld, det, done} =
        {tbl[i].rstn, tbl[i].en, tbl[i].os, tbl[i].vld, tbl[i].det, tbl[i].done};
      cyc();
      chk($sformatf("tbl_row%0d", i),
          32'({o_state, o_start, o_agc_en_n, o_frame_pulse, o_busy}),
          32'({tbl[i].st, tbl[i].start, tbl[i].agcn, tbl[i].pulse, tbl[i].st != 3'd0}));
    end
    {rstn, en, oneshot, vld, det, done} = 6'b0;

    // Full burst: agc=4, detect at strobe 10, done 200 strobes later
    cyc();
    chk_reset_vals("reset");
    rstn = 1'b1; en = 1'b1; agc = 8'd4; tmo = '0; auto_vld = 1'b1; ph = 0;
    cyc();
    chk("start_after_en", 32'(o_start), 32'd1);
    wait_strobes(10, 1'b1, 1'b0);
    chk("agc_entered", 32'(o_state), 32'd3);
    wait_strobes(3, 1'b0, 1'b0);
    chk("agc_still_on", 32'(o_agc_en_n), 32'd0);
    wait_strobes(1, 1'b0, 1'b0);
    chk("agc_frozen", 32'(o_agc_en_n), 32'd1);
    wait_strobes(196, 1'b0, 1'b1);
    chk("done_pulse", 32'(o_frame_pulse), 32'd1);
    chk("fcnt_1", 32'(o_frame_cnt), STATS ? 32'd1 : 32'd0);
    gap_len = 0;
    for (int k = 0; k < 20 && o_start == 1'b0; k++) begin gap_len++; cyc(); end
    chk("gap_len", 32'(gap_len), 32'(GAP));
    chk("rearm", 32'(o_state), 32'd1);

    // Timeout after 50 strobes
    tmo = CW'(50); agc = 8'd0;
    wait_state(3'd2);
    wait_strobes(1, 1'b1, 1'b0);
    chk("recv_direct", 32'(o_state), 32'd4);
    wait_strobes(49, 1'b0, 1'b0);
    chk("recv_49", 32'(o_state), 32'd4);
    wait_strobes(1, 1'b0, 1'b0);
    chk("timeout_exit", 32'(o_state), 32'd5);
    chk("tcnt_1", 32'(o_timeout_cnt), STATS ? 32'd1 : 32'd0);
    chk("fcnt_keep", 32'(o_frame_cnt), STATS ? 32'd1 : 32'd0);

    // Done coincident with the 50th strobe
    wait_state(3'd2);
    wait_strobes(1, 1'b1, 1'b0);
    wait_strobes(49, 1'b0, 1'b0);
    wait_strobes(1, 1'b0, 1'b1);
    chk("coinc_pulse", 32'(o_frame_pulse), 32'd1);
    chk("coinc_fcnt", 32'(o_frame_cnt), STATS ? 32'd2 : 32'd0);
    chk("coinc_tcnt", 32'(o_timeout_cnt), STATS ? 32'd1 : 32'd0);

    // Disable in SEARCH aborts to GAP, then IDLE
    wait_state(3'd2);
    en = 1'b0;
    cyc();
    chk("abort_gap", 32'(o_state), 32'd5);
    repeat (5) cyc();
    chk("abort_gap_hold", 32'(o_state), 32'd5);
    cyc();
    chk("abort_idle", 32'(o_busy), 32'd0);

    // Disable in RECV does not abort
    tmo = '0; en = 1'b1;
    wait_state(3'd2);
    wait_strobes(1, 1'b1, 1'b0);
    en = 1'b0;
    wait_strobes(5, 1'b0, 1'b0);
    chk("recv_no_abort", 32'(o_state), 32'd4);
    wait_strobes(1, 1'b0, 1'b1);
    chk("recv_done_pulse", 32'(o_frame_pulse), 32'd1);
    repeat (GAP) cyc();
    chk("recv_then_idle", 32'(o_state), 32'd0);

    // Oneshot with AGC skipped
    en = 1'b1; oneshot = 1'b1; agc = 8'd0;
    wait_state(3'd2);
    wait_strobes(1, 1'b1, 1'b0);
    chk("oneshot_recv", 32'(o_state), 32'd4);
    wait_strobes(3, 1'b0, 1'b1);
    chk("oneshot_gap", 32'(o_state), 32'd5);
    repeat (GAP) cyc();
    chk("oneshot_idle", 32'(o_state), 32'd0);
    chk("oneshot_busy", 32'(o_busy), 32'd0);
    en = 1'b0; oneshot = 1'b0;

    // Reset mid-RECV, with a coincident done that must not count
    en = 1'b1;
    wait_state(3'd2);
    wait_strobes(1, 1'b1, 1'b0);
    chk("pre_reset_recv", 32'(o_state), 32'd4);
    rstn = 1'b0; done = 1'b1;
    cyc();
    done = 1'b0; rstn = 1'b1;
    chk_reset_vals("midrst");

    // Saturation, then clear coincident with done
    for (int f = 0; f < MAXC + 5; f++) begin
      wait_state(3'd2);
      det = 1'b1; cyc(); det = 1'b0;
      done = 1'b1; cyc(); done = 1'b0;
    end
    chk("fcnt_sat", 32'(o_frame_cnt), STATS ? 32'(MAXC) : 32'd0);
    wait_state(3'd2);
    det = 1'b1; cyc(); det = 1'b0;
    done = 1'b1; clr = 1'b1; cyc(); done = 1'b0; clr = 1'b0;
    chk("clr_pulse", 32'(o_frame_pulse), 32'd1);
    chk("clr_wins", 32'(o_frame_cnt), 32'd0);

    // Randomized traffic against the model
    auto_vld = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rstn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 49) == 0) agc = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0) tmo = CW'($urandom_range(0, 20));
      vld  = ($urandom_range(0, 3) == 0);
      det  = ($urandom_range(0, 9) == 0);
      done = ($urandom_range(0, 19) == 0);
      clr  = ($urandom_range(0, 59) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
